// File: rtl/gb_mem_target_ram_if.sv
// IRetroMemoryPort signal bundle between a bus initiator (master) and a
// memory target (slave). Clock, reset and clock enable stay outside.
interface gb_mem_target_ram_if #(
  parameter int AddrWidth = 14
);
  logic                 Access;
  logic                 Write;
  logic [AddrWidth-1:0] Address;
  logic [7:0]           DToTarget;
  logic [7:0]           DToInitiator;
  logic                 Ready;
  logic                 DataReady;

  modport master (
    output Access, Write, Address, DToTarget,
    input  DToInitiator, Ready, DataReady
  );

  modport slave (
    input  Access, Write, Address, DToTarget,
    output DToInitiator, Ready, DataReady
  );
endinterface

// File: rtl/gb_mem_target_ram.sv
// Byte-wide on-chip RAM target for the IRetroMemoryPort with a fixed read latency.
// Optional macro GB_MEM_TARGET_INIT_CLEAR_EN zeroes the whole RAM after every reset.
module gb_mem_target_ram #(
  parameter int AddrWidth   = 14,
  parameter int ReadLatency = 2,
  parameter     DeviceType  = "Xilinx"
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               ClkEn,
  gb_mem_target_ram_if.slave bus
);

  localparam int Depth = 2 ** AddrWidth;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StClear = 1'b1;
`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
  localparam logic [0:0] StInit  = StClear;
`else
  localparam logic [0:0] StInit  = StRun;
`endif

  logic [0:0]             state_q, state_d;
  logic                   ready_q, ready_d;
  logic [ReadLatency-1:0] pipeValid_q, pipeValid_d;
  logic [7:0]             pipeData_q [ReadLatency];
  logic [7:0]             pipeData_d [ReadLatency];
`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
  logic [AddrWidth-1:0]   clearAddr_q, clearAddr_d;
`endif

  logic                   accept;
  logic                   acceptRead;
  logic                   memWe;
  logic [AddrWidth-1:0]   memWAddr;
  logic [7:0]             memWData;
  logic [7:0]             memRData;

  assign accept     = ClkEn & bus.Access & ready_q;
  assign acceptRead = accept & ~bus.Write;

  always_comb begin
    state_d  = state_q;
    memWe    = accept & bus.Write;
    memWAddr = bus.Address;
    memWData = bus.DToTarget;
`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
    clearAddr_d = clearAddr_q;
    if (state_q == StClear) begin
      memWe    = ClkEn;
      memWAddr = clearAddr_q;
      memWData = 8'h00;
      if (ClkEn) begin
        clearAddr_d = clearAddr_q + AddrWidth'(1);
        if (clearAddr_q == '1) begin
          state_d = StRun;
        end
      end
    end
`endif
  end

  // Ready follows the state the block is about to be in, so it rises together with RUN.
  always_comb begin
    ready_d = ready_q;
    if (ClkEn) begin
      ready_d = (state_d == StRun);
    end
  end

  // The RAM is sampled at the accepting edge into the pipeline head, so a write one
  // cycle earlier is visible and a write one cycle later cannot disturb the result.
  always_comb begin
    pipeValid_d = pipeValid_q;
    pipeData_d  = pipeData_q;
    if (ClkEn) begin
      pipeValid_d[0] = acceptRead;
      pipeData_d[0]  = memRData;
      for (int i = 1; i < ReadLatency; i++) begin
        pipeValid_d[i] = pipeValid_q[i-1];
        pipeData_d[i]  = pipeData_q[i-1];
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StInit;
      ready_q     <= 1'b0;
      pipeValid_q <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        pipeData_q[i] <= 8'h00;
      end
`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
      clearAddr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      pipeValid_q <= pipeValid_d;
      pipeData_q  <= pipeData_d;
`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
      clearAddr_q <= clearAddr_d;
`endif
    end
  end

  generate
    if (DeviceType == "Xilinx") begin : gXilinxRam
      (* ram_style = "distributed" *) logic [7:0] mem [Depth];

      always_ff @(posedge Clk) begin
        if (memWe) begin
          mem[memWAddr] <= memWData;
        end
      end

      assign memRData = mem[bus.Address];
    end else begin : gGenericRam
      logic [7:0] mem [Depth];

      always_ff @(posedge Clk) begin
        if (memWe) begin
          mem[memWAddr] <= memWData;
        end
      end

      assign memRData = mem[bus.Address];
    end
  endgenerate

  assign bus.Ready        = ready_q;
  assign bus.DataReady    = pipeValid_q[ReadLatency-1];
  assign bus.DToInitiator = pipeData_q[ReadLatency-1];

endmodule

// File: tb/tb_gb_mem_target_ram.sv
// Directed table-driven bench for gb_mem_target_ram (ReadLatency=2); with
// GB_MEM_TARGET_INIT_CLEAR_EN defined it runs at AddrWidth=4 and checks the clear sweep.
module tb_gb_mem_target_ram;

`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
  localparam int AW         = 4;
  localparam int ReadyDelay = 16;
`else
  localparam int AW         = 14;
  localparam int ReadyDelay = 1;
`endif

  typedef struct {
    string       name;
    bit          en;
    bit          acc;
    bit          wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
    bit          expRdy;
    bit          expDr;
    logic [7:0]  expData;
  } vec_t;

  logic Clk = 1'b0;
  logic nReset;
  logic ClkEn;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  gb_mem_target_ram_if #(.AddrWidth(AW)) bus ();

  gb_mem_target_ram #(
    .AddrWidth  (AW),
    .ReadLatency(2),
    .DeviceType ("Xilinx")
  ) dut (
    .Clk   (Clk),
    .nReset(nReset),
    .ClkEn (ClkEn),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit acc, input bit wr,
                               input logic [13:0] a, input logic [7:0] d);
    ClkEn         = en;
    bus.Access    = acc;
    bus.Write     = wr;
    bus.Address   = a[AW-1:0];
    bus.DToTarget = d;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic void addVec(input string n, input bit en, input bit acc, input bit wr,
                                 input logic [13:0] a, input logic [7:0] d,
                                 input bit r, input bit dr, input logic [7:0] ed);
    vec_t v;
    v.name = n; v.en = en; v.acc = acc; v.wr = wr; v.addr = a; v.wdata = d;
    v.expRdy = r; v.expDr = dr; v.expData = ed;
    vecs.push_back(v);
  endfunction

  // Holds reset for a few edges, releases it and counts ClkEn cycles until Ready.
  task automatic resetDut();
    int  n;
    bit  sawDr;
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 8'h00);
    nReset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    nReset = 1'b1;
    n     = 0;
    sawDr = 1'b0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      step();
      n++;
      if (bus.DataReady !== 1'b0) sawDr = 1'b1;
    end
    checkOutput("ReadyRiseDelay", n, ReadyDelay);
    checkOutput("NoDataReadyDuringStartup", {31'd0, sawDr}, 0);
  endtask

  initial begin
    vec_t v;

    // Request in vector i is accepted at that vector's edge; its DataReady is seen
    // one vector later (two cycles after the request cycle).
    addVec("wr123",    1, 1, 1, 14'h0123, 8'hA5, 1, 0, 8'h00);
    addVec("rd123",    1, 1, 0, 14'h0123, 8'h00, 1, 0, 8'h00);
    addVec("rsp123",   1, 0, 0, 14'h0000, 8'h00, 1, 1, 8'hA5);
    addVec("idle0",    1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("pre0",     1, 1, 1, 14'h0000, 8'h10, 1, 0, 8'h00);
    addVec("pre1",     1, 1, 1, 14'h0001, 8'h11, 1, 0, 8'h00);
    addVec("pre2",     1, 1, 1, 14'h0002, 8'h12, 1, 0, 8'h00);
    addVec("pre3",     1, 1, 1, 14'h0003, 8'h13, 1, 0, 8'h00);
    addVec("b2bRd0",   1, 1, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("b2bRd1",   1, 1, 0, 14'h0001, 8'h00, 1, 1, 8'h10);
    addVec("b2bRd2",   1, 1, 0, 14'h0002, 8'h00, 1, 1, 8'h11);
    addVec("b2bRd3",   1, 1, 0, 14'h0003, 8'h00, 1, 1, 8'h12);
    addVec("b2bTail",  1, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h13);
    addVec("b2bDone",  1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("hzPre",    1, 1, 1, 14'h0200, 8'h11, 1, 0, 8'h00);
    addVec("hzRdOld",  1, 1, 0, 14'h0200, 8'h00, 1, 0, 8'h00);
    addVec("hzWr",     1, 1, 1, 14'h0200, 8'h22, 1, 1, 8'h11);
    addVec("hzRdNew",  1, 1, 0, 14'h0200, 8'h00, 1, 0, 8'h00);
    addVec("hzRspNew", 1, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h22);
    addVec("hzDone",   1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("stRd",     1, 1, 0, 14'h0002, 8'h00, 1, 0, 8'h00);
    addVec("stall1",   0, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("stall2Acc",0, 1, 0, 14'h0003, 8'h00, 1, 0, 8'h00);
    addVec("stall3",   0, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("stRsp",    1, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h12);
    addVec("stNoDup",  1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("hdRd",     1, 1, 0, 14'h0001, 8'h00, 1, 0, 8'h00);
    addVec("hdRsp",    1, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h11);
    addVec("hdHold1",  0, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h11);
    addVec("hdHold2",  0, 0, 0, 14'h0000, 8'h00, 1, 1, 8'h11);
    addVec("hdDone",   1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);
    addVec("hdNoDup",  1, 0, 0, 14'h0000, 8'h00, 1, 0, 8'h00);

    nReset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 8'h00);
    #1;
    checkOutput("rstReady",     {31'd0, bus.Ready}, 0);
    checkOutput("rstDataReady", {31'd0, bus.DataReady}, 0);
    checkOutput("rstData",      {24'd0, bus.DToInitiator}, 0);
    resetDut();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.en, v.acc, v.wr, v.addr, v.wdata);
      step();
      checkOutput({v.name, " Ready"}, {31'd0, bus.Ready}, {31'd0, v.expRdy});
      checkOutput({v.name, " DataReady"}, {31'd0, bus.DataReady}, {31'd0, v.expDr});
      if (v.expDr) begin
        checkOutput({v.name, " Data"}, {24'd0, bus.DToInitiator}, {24'd0, v.expData});
      end
    end

    // Reset with two reads in flight must clear outputs without a clock edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0001, 8'h00);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0002, 8'h00);
    step();
    checkOutput("midRstPreDr",   {31'd0, bus.DataReady}, 1);
    checkOutput("midRstPreData", {24'd0, bus.DToInitiator}, 32'h11);
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("midRstReady",     {31'd0, bus.Ready}, 0);
    checkOutput("midRstDataReady", {31'd0, bus.DataReady}, 0);
    checkOutput("midRstData",      {24'd0, bus.DToInitiator}, 0);
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("noStale%0d", i), {31'd0, bus.DataReady}, 0);
    end

`ifdef GB_MEM_TARGET_INIT_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 14'(i), 8'h00);
      step();
      if (i > 0) begin
        checkOutput($sformatf("clrDr%0d", i - 1), {31'd0, bus.DataReady}, 1);
        checkOutput($sformatf("clrData%0d", i - 1), {24'd0, bus.DToInitiator}, 0);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 8'h00);
    step();
    checkOutput("clrDr15",   {31'd0, bus.DataReady}, 1);
    checkOutput("clrData15", {24'd0, bus.DToInitiator}, 0);
    step();
    checkOutput("clrDone",   {31'd0, bus.DataReady}, 0);
`else
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0001, 8'h00);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 8'h00);
    step();
    checkOutput("keepDr",   {31'd0, bus.DataReady}, 1);
    checkOutput("keepData", {24'd0, bus.DToInitiator}, 32'h11);
    step();
    checkOutput("keepDone", {31'd0, bus.DataReady}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_mem_target_ram.md
Name: gb_mem_target_ram

Overview:
- Target (responder) end of the IRetroMemoryPort protocol.
- Serves single-byte read/write requests from a bus initiator out of on-chip RAM. An example initiator is the system bus controller driving its SystemRAM or VideoRAM port.
- Provides a fixed, parameterised read latency, back-to-back acceptance, and a defined Ready/DataReady handshake.
- Instantiated once per WRAM/VRAM bank group.

Parameters:
- AddrWidth, 14, address bits; depth is 2**AddrWidth bytes (16 KiB default).
- ReadLatency, 2, cycles from request acceptance to DataReady; legal range 1..4.
- DeviceType, "Xilinx", selects the RAM inference style; no functional effect.

Ports:
- Clk  in  1  system clock; one clock domain.
- nReset  in  1  asynchronous, active-low reset.
- ClkEn  in  1  clock enable; state advances only when high.
- Access  in  1  initiator requests a transfer this cycle.
- Write  in  1  1 = write, 0 = read; valid while Access is high.
- Address  in  AddrWidth  byte address; valid while Access is high.
- DToTarget  in  8  write data; valid while Access is high and Write is high.
- DToInitiator  out  8  read data; valid while DataReady is high.
- Ready  out  1  target can accept a request this cycle.
- DataReady  out  1  DToInitiator holds the result of the oldest outstanding read.

Behaviour:
- Reset (nReset low, asynchronous) sets the following values:
  - Ready=0, DataReady=0, DToInitiator=8'h00.
  - Read pipeline valid bits are cleared, so in-flight reads are discarded and never answered.
  - RAM contents are not reset, except when the optional feature is enabled.
- Ready rises on the first ClkEn cycle after reset release. With the optional feature enabled, it rises after the clear sweep completes instead.
- Acceptance: a request is accepted on a rising Clk edge where ClkEn, Access and Ready are all 1.
  - Address, Write and DToTarget are sampled at that edge only.
  - Access with Ready=0 is ignored. The initiator must hold the request until accepted.
- Write: the RAM is updated at the accepting edge. No DataReady is generated. The next request may be accepted on the next ClkEn cycle.
- Read:
  - The RAM is read at the accepting edge.
  - The result travels down a ReadLatency-deep pipeline of {valid, data} that advances only on ClkEn.
  - DataReady=1 and DToInitiator=data exactly ReadLatency ClkEn-cycles after acceptance.
  - When ClkEn is low, DataReady and DToInitiator hold their values.
  - A read is answered once: DataReady is high for a single ClkEn cycle per read.
- Throughput:
  - One request per ClkEn cycle, with reads and writes freely mixed.
  - Up to ReadLatency reads may be outstanding.
  - Ready stays 1 in steady state; there is no backpressure from DataReady, because the initiator must always accept.
- Ordering: read responses are returned in acceptance order.
- Hazards:
  - A read accepted after a write to the same address returns the new data, including when the write was in the immediately preceding cycle.
  - A read accepted before a write returns the old data, even if the write lands while the read is still in the pipeline.
- Address is always in range by width; there are no out-of-range or wrap cases.
- Internal states:
  - RUN: normal operation.
  - CLEAR: only with the optional feature enabled.
  - RUN is entered from reset, or from CLEAR when the clear address reaches 2**AddrWidth-1.

Optional Feature:
- Macro GB_MEM_TARGET_INIT_CLEAR_EN.
- Defined:
  - After reset release, the block enters CLEAR and writes 8'h00 to addresses 0..2**AddrWidth-1, one per ClkEn cycle, ascending.
  - Ready=0 throughout CLEAR.
  - RUN is entered on the ClkEn cycle after the last address is written.
  - Reset asserted mid-sweep aborts it; the sweep restarts from address 0 after release.
- Undefined: the block comes up directly in RUN. RAM contents after power-up are whatever the device initialises them to.

Test Plan:
- Reset then single write/read: write 8'hA5 at address 14'h0123, then read 14'h0123. DataReady rises exactly 2 cycles after the read is accepted (ReadLatency=2), with DToInitiator=8'hA5. DataReady never asserts for the write.
- Back-to-back reads: preload 14'h0000..14'h0003 with 8'h10..8'h13, then issue reads on 4 consecutive cycles. Ready stays 1 throughout. DataReady is high for 4 consecutive cycles returning 8'h10, 8'h11, 8'h12, 8'h13 in order.
- Write/read hazard: preload 14'h0200 with 8'h11. Read 14'h0200, then write 8'h22 on the next cycle, then read again on the following cycle. The responses are 8'h11 then 8'h22.
- ClkEn stall: ClkEn is held low for 3 cycles while a read is in flight. The DataReady timing stretches by exactly 3 cycles. DataReady and DToInitiator hold their values while ClkEn is low, and there is no duplicate response.
- Reset mid-operation: assert nReset with 2 reads outstanding. Ready=0, DataReady=0 and DToInitiator=8'h00 take effect immediately, without waiting for a clock. No stale response appears after release.
- GB_MEM_TARGET_INIT_CLEAR_EN defined, with AddrWidth=4: Ready=0 for exactly 16 ClkEn cycles after reset release, then 1. Reads of 14'h0..14'hF all return 8'h00.
